router_fifo_param: RTL

//  Parametrised per-port output FIFO for the 1xN router; the next generation of the fixed 16x9 router FIFO.

---
 rtl/router_fifo_param_if.sv | 34 +++
 rtl/router_fifo_param.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/router_fifo_param_if.sv
// Write/read handshake and status bundle for one router output port FIFO.
// The master side is the router/destination pair; the FIFO itself is the slave.
interface router_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                       soft_reset;
    logic                       write_en;
    logic                       lfd_state;
    logic [DATA_W-1:0]          data_in;
    logic                       read_enb;
    logic [DATA_W-1:0]          data_out;
    logic                       out_valid;
    logic                       empty;
    logic                       full;
    logic                       almost_full;
    logic                       almost_empty;
    logic [$clog2(DEPTH):0]     occupancy;
    logic                       pkt_done;
    logic                       wr_err;
    logic                       rd_err;

    modport master (
        output soft_reset, write_en, lfd_state, data_in, read_enb,
        input  data_out, out_valid, empty, full, almost_full, almost_empty,
               occupancy, pkt_done, wr_err, rd_err
    );

    modport slave (
        input  soft_reset, write_en, lfd_state, data_in, read_enb,
        output data_out, out_valid, empty, full, almost_full, almost_empty,
               occupancy, pkt_done, wr_err, rd_err
    );
endinterface

// File: rtl/router_fifo_param.sv
// Per-port router output FIFO: tagged byte storage, registered read data and flags,
// packet-length tracking on the read side, and overflow/underflow pulses.
module router_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input logic                 clk,
    input logic                 rst,
    router_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = DATA_W - 1;
    localparam logic [PW-1:0] AF_LVL = PW'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_MARGIN);

    logic [DATA_W:0]    mem_q [DEPTH];

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      occ_q, occ_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               af_q, af_d;
    logic               ae_q, ae_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic               pkt_done_q, pkt_done_d;
    logic               wr_err_q, wr_err_d;
    logic               rd_err_q, rd_err_d;
    logic [CW-1:0]      pkt_cnt_q, pkt_cnt_d;

    logic               wr_acc;
    logic               rd_acc;
    logic               mem_we;
    logic [DATA_W:0]    rd_entry;

    always_comb begin
        wr_acc   = bus.write_en && !full_q;
        rd_acc   = bus.read_enb && !empty_q;
        mem_we   = wr_acc && !bus.soft_reset;
        rd_entry = mem_q[rd_ptr_q[AW-1:0]];

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_out_d  = data_out_q;
        pkt_cnt_d   = pkt_cnt_q;
        out_valid_d = 1'b0;
        pkt_done_d  = 1'b0;
        wr_err_d    = bus.write_en && full_q;
        rd_err_d    = bus.read_enb && empty_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);

        if (rd_acc) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            data_out_d  = rd_entry[DATA_W-1:0];
            out_valid_d = 1'b1;
            // A header always restarts the count, even if the previous packet was cut short.
            if (rd_entry[DATA_W]) begin
                pkt_cnt_d = CW'(rd_entry[DATA_W-1:2]) + CW'(1);
            end else if (pkt_cnt_q != '0) begin
                pkt_cnt_d  = pkt_cnt_q - CW'(1);
                pkt_done_d = (pkt_cnt_q == CW'(1));
            end
        end

        occ_d   = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        af_d    = (occ_d >= AF_LVL);
        ae_d    = (occ_d <= AE_LVL);

        if (bus.soft_reset) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            empty_d     = 1'b1;
            full_d      = 1'b0;
            af_d        = 1'b0;
            ae_d        = 1'b1;
            data_out_d  = '0;
            out_valid_d = 1'b0;
            pkt_done_d  = 1'b0;
            wr_err_d    = 1'b0;
            rd_err_d    = 1'b0;
            pkt_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            pkt_done_q  <= pkt_done_d;
            wr_err_q    <= wr_err_d;
            rd_err_q    <= rd_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end

    assign bus.data_out     = data_out_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.occupancy    = occ_q;
    assign bus.pkt_done     = pkt_done_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_err       = rd_err_q;
endmodule
